// File: rtl/fa_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one FA cell, LSB first, registered carry chain.
// Optional signed-overflow output Ovf when FA_SERIAL_ADD_OVF_EN is defined.
module FA (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);
  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

module fa_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Cout
`ifdef FA_SERIAL_ADD_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_s;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_s_next;

  FA u_fa (
    .A     (r_a[0]),
    .B     (r_b[0]),
    .Cin   (r_c),
    .Sum   (w_sum),
    .Carry (w_carry)
  );

  // The new sum bit enters at the MSB; after WIDTH shifts it is aligned.
  assign w_s_next = {w_sum, r_s};

  assign Busy = (r_state == S_RUN);
  assign Done = (r_state == S_DONE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      Sum_out <= '0;
      Cout    <= 1'b0;
`ifdef FA_SERIAL_ADD_OVF_EN
      Ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_a     <= A_in;
            r_b     <= B_in;
            r_c     <= Cin_in;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_s   <= w_s_next[WIDTH-1:1];
          r_c   <= w_carry;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            Sum_out <= w_s_next;
            Cout    <= w_carry;
`ifdef FA_SERIAL_ADD_OVF_EN
            Ovf     <= r_c ^ w_carry;
`endif
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// Scoreboard bench for fa_serial_add_ctrl at WIDTH=8 and WIDTH=2.
// Define FA_SERIAL_ADD_OVF_EN to also check Ovf.
module tb_fa_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

`ifdef FA_SERIAL_ADD_OVF_EN
  logic ovf8, ovf2;
`endif

  int checks = 0;
  int errors = 0;
  int done8_n = 0;
  int done2_n = 0;

  logic [9:0] q8[$];
  logic [3:0] q2[$];

  always #5 clk = ~clk;

  fa_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Start   (start8),
    .A_in    (a8),
    .B_in    (b8),
    .Cin_in  (cin8),
    .Busy    (busy8),
    .Done    (done8),
    .Sum_out (sum8),
    .Cout    (cout8)
`ifdef FA_SERIAL_ADD_OVF_EN
    ,
    .Ovf     (ovf8)
`endif
  );

  fa_serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Start   (start2),
    .A_in    (a2),
    .B_in    (b2),
    .Cin_in  (cin2),
    .Busy    (busy2),
    .Done    (done2),
    .Sum_out (sum2),
    .Cout    (cout2)
`ifdef FA_SERIAL_ADD_OVF_EN
    ,
    .Ovf     (ovf2)
`endif
  );

  // {ovf, cout, sum}; ovf by the sign rule on operands and result
  function automatic logic [9:0] exp8(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic c);
    logic [8:0] s;
    logic o;
    s = {1'b0, a} + {1'b0, b} + {8'b0, c};
    o = (a[7] == b[7]) && (s[7] != a[7]);
    return {o, s};
  endfunction

  function automatic logic [3:0] exp2(input logic [1:0] a,
                                      input logic [1:0] b,
                                      input logic c);
    logic [2:0] s;
    logic o;
    s = {1'b0, a} + {1'b0, b} + {2'b0, c};
    o = (a[1] == b[1]) && (s[1] != a[1]);
    return {o, s};
  endfunction

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && done8) begin
      done8_n++;
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL mon8_unexpected_done sum=%h cout=%b", sum8, cout8);
      end else begin
        e = q8.pop_front();
        if ({cout8, sum8} !== e[8:0]) begin
          errors++;
          $display("FAIL mon8_result got=%h exp=%h", {cout8, sum8}, e[8:0]);
        end
`ifdef FA_SERIAL_ADD_OVF_EN
        checks++;
        if (ovf8 !== e[9]) begin
          errors++;
          $display("FAIL mon8_ovf got=%b exp=%b", ovf8, e[9]);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && done2) begin
      done2_n++;
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL mon2_unexpected_done sum=%h cout=%b", sum2, cout2);
      end else begin
        e = q2.pop_front();
        if ({cout2, sum2} !== e[2:0]) begin
          errors++;
          $display("FAIL mon2_result got=%h exp=%h", {cout2, sum2}, e[2:0]);
        end
`ifdef FA_SERIAL_ADD_OVF_EN
        checks++;
        if (ovf2 !== e[3]) begin
          errors++;
          $display("FAIL mon2_ovf got=%b exp=%b", ovf2, e[3]);
        end
`endif
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input bit poke,
                      output int nb, output bit got);
    @(posedge clk);
    #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(exp8(a, b, c));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~a; b8 = 8'($urandom); cin8 = ~c;
    nb = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) got = 1;
      if (poke && nb == 3) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      end
      if (poke && nb == 5) start8 = 1'b0;
    end
  endtask

  task automatic chk_run8(input string nm, input int nb, input bit got);
    checks++;
    if (!got || nb !== 8) begin
      errors++;
      $display("FAIL %s_timing busy_cycles=%0d done_seen=%0b exp 8/1",
               nm, nb, got);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse done=%b busy=%b exp 0/0", nm, done8, busy8);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_out8 got=%h exp=0", {busy8, done8, cout8, sum8});
    end
    checks++;
    if ({busy2, done2, cout2, sum2} !== 5'd0) begin
      errors++;
      $display("FAIL reset_out2 got=%h exp=0", {busy2, done2, cout2, sum2});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b exp 0/0", busy8, done8);
    end
  endtask

  task automatic test_basic;
    int nb;
    bit got;
    run8(8'h5A, 8'h3C, 1'b0, 1'b0, nb, got);
    checks++;
    if (sum8 !== 8'h96 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got=%b_%h exp 0_96", cout8, sum8);
    end
    chk_run8("basic", nb, got);
  endtask

  task automatic test_carry;
    int nb;
    bit got;
    run8(8'hFF, 8'h00, 1'b1, 1'b0, nb, got);
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL carry_cin got=%b_%h exp 1_00", cout8, sum8);
    end
    chk_run8("carry_cin", nb, got);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, nb, got);
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL carry_b got=%b_%h exp 1_00", cout8, sum8);
    end
    chk_run8("carry_b", nb, got);
  endtask

  task automatic test_start_ignored;
    int nb;
    bit got;
    run8(8'h12, 8'h34, 1'b1, 1'b1, nb, got);
    chk_run8("start_ignored", nb, got);
  endtask

  task automatic test_back_to_back;
    int d0;
    int bad;
    logic [7:0] a, b;
    logic c;
    d0 = done8_n;
    bad = 0;
    @(posedge clk);
    #1;
    start8 = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int cy = 0; cy < 9; cy++) begin
        a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
        a8 = a; b8 = b; cin8 = c;
        if (cy == 0) q8.push_back(exp8(a, b, c));
        @(negedge clk);
        if (cy >= 1 && (busy8 !== 1'b1 || done8 !== 1'b0)) bad++;
        if (cy == 0 && op > 0 && (busy8 !== 1'b0 || done8 !== 1'b1)) bad++;
        @(posedge clk);
        #1;
      end
    end
    start8 = 1'b0;
    @(negedge clk);
    if (done8 !== 1'b1) bad++;
    @(negedge clk);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_cadence bad_cycles=%0d exp 0", bad);
    end
    checks++;
    if (done8_n - d0 != 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp 4", done8_n - d0);
    end
  endtask

  task automatic test_reset_midrun;
    int nb;
    @(posedge clk);
    #1;
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    nb = 0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      @(negedge clk);
      if (busy8) nb++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset got=%h exp=0", {busy8, done8, cout8, sum8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8 !== 1'b0 || done8 !== 1'b0) nb++;
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL midrun_stay_idle active_cycles=%0d exp 0", nb);
    end
  endtask

  task automatic test_sweep_w2;
    int d0;
    int bad;
    int nb;
    bit got;
    logic [4:0] v;
    d0 = done2_n;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      v = 5'(k);
      @(posedge clk);
      #1;
      a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4]; start2 = 1'b1;
      q2.push_back(exp2(v[1:0], v[3:2], v[4]));
      @(posedge clk);
      #1;
      start2 = 1'b0;
      a2 = ~v[1:0];
      nb = 0;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (busy2) nb++;
        if (done2) got = 1;
      end
      if (!got || nb != 2) bad++;
    end
    @(negedge clk);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_timing bad_ops=%0d exp 0", bad);
    end
    checks++;
    if (done2_n - d0 != 32) begin
      errors++;
      $display("FAIL sweep_done_count got=%0d exp 32", done2_n - d0);
    end
  endtask

`ifdef FA_SERIAL_ADD_OVF_EN
  task automatic test_ovf;
    int nb;
    bit got;
    run8(8'h7F, 8'h01, 1'b0, 1'b0, nb, got);
    checks++;
    if ({ovf8, cout8, sum8} !== 10'h280) begin
      errors++;
      $display("FAIL ovf_7f got=%h exp 280", {ovf8, cout8, sum8});
    end
    chk_run8("ovf_7f", nb, got);
    run8(8'h80, 8'h80, 1'b0, 1'b0, nb, got);
    checks++;
    if ({ovf8, cout8, sum8} !== 10'h300) begin
      errors++;
      $display("FAIL ovf_80 got=%h exp 300", {ovf8, cout8, sum8});
    end
    chk_run8("ovf_80", nb, got);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, nb, got);
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ff got=%b exp 0", ovf8);
    end
    chk_run8("ovf_ff", nb, got);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_start_ignored;
    test_back_to_back;
    test_reset_midrun;
    test_sweep_w2;
`ifdef FA_SERIAL_ADD_OVF_EN
    test_ovf;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain q8=%0d q2=%0d exp 0/0",
               q8.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
